// File: rtl/anf_fl_tex_mem_arb_if.sv
// Texture fetch client / memory read bus bundle for anf_fl_tex_mem_arb.
// slave  : the arbiter's view (clients in, memory requests out).
// master : the environment's view (client requests and memory model).
interface anf_fl_tex_mem_arb_if #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 64
);
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ-1:0]        resp_valid;
  logic [DATA_W-1:0]         resp_data;
  logic                      mem_rd_req;
  logic [ADDR_W-1:0]         mem_rd_addr;
  logic                      mem_rd_ack;
  logic                      mem_rd_valid;
  logic [DATA_W-1:0]         mem_rd_data;
  logic                      err_orphan;

  modport slave (
    input  req_valid, req_addr, mem_rd_ack, mem_rd_valid, mem_rd_data,
    output req_ready, resp_valid, resp_data, mem_rd_req, mem_rd_addr, err_orphan
  );

  modport master (
    output req_valid, req_addr, mem_rd_ack, mem_rd_valid, mem_rd_data,
    input  req_ready, resp_valid, resp_data, mem_rd_req, mem_rd_addr, err_orphan
  );
endinterface

// File: rtl/anf_fl_tex_mem_arb.sv
// Texture unit memory read arbiter: round-robin grant over NUM_REQ fetch clients,
// up to MAX_OUT reads in flight, in-order responses routed back via a tag FIFO.
// Optional feature macro: ANFFL_TEX_ARB_META_PRIO_EN gives port 0 (metadata)
// absolute priority; the remaining ports stay round-robin and port-0 grants do
// not move the round-robin pointer.
module anf_fl_tex_mem_arb #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 64,
  parameter int unsigned MAX_OUT = 4
) (
  input logic                 clk,
  input logic                 reset,
  anf_fl_tex_mem_arb_if.slave bus
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned PTR_W = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } state_t;

  state_t             state;
  state_t             stateNxt;

  logic [CNT_W-1:0]   count;
  logic [CNT_W-1:0]   cntAfter;
  logic [PTR_W-1:0]   headPtr;
  logic [PTR_W-1:0]   tailPtr;
  logic [IDX_W-1:0]   tagMem [MAX_OUT];
  logic [IDX_W-1:0]   headIdx;

  logic [IDX_W-1:0]   rrPtr;
  logic [IDX_W-1:0]   curIdx;
  logic [IDX_W-1:0]   grantIdx;
  logic [ADDR_W-1:0]  grantAddr;
  logic [ADDR_W-1:0]  memRdAddr;
  logic [NUM_REQ-1:0] grantOh;
  logic [NUM_REQ-1:0] headOh;
  logic [NUM_REQ-1:0] respValid;
  logic [DATA_W-1:0]  respData;
  logic               errOrphan;

  logic               push;
  logic               pop;
  logic               eligible;
  logic               grantAny;
  logic               grantOk;
  logic               rrAdv;

  // Tag FIFO occupancy after this cycle's push/pop decides whether a new grant fits
  always_comb begin
    push     = (state == ISSUE) && bus.mem_rd_ack;
    pop      = bus.mem_rd_valid && (count != '0);
    cntAfter = count + CNT_W'(push) - CNT_W'(pop);
    eligible = cntAfter < CNT_W'(MAX_OUT);
  end

  // Round-robin search from rrPtr upward, wrapping at NUM_REQ-1
  always_comb begin
    int unsigned          cand;
    logic [IDX_W-1:0]     candIdx;
    cand     = 0;
    candIdx  = '0;
    grantAny = 1'b0;
    grantIdx = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = 32'(rrPtr) + k;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      candIdx = IDX_W'(cand);
`ifdef ANFFL_TEX_ARB_META_PRIO_EN
      if (!grantAny && bus.req_valid[candIdx] && (candIdx != '0)) begin
`else
      if (!grantAny && bus.req_valid[candIdx]) begin
`endif
        grantAny = 1'b1;
        grantIdx = candIdx;
      end
    end
`ifdef ANFFL_TEX_ARB_META_PRIO_EN
    if (bus.req_valid[0]) begin
      grantAny = 1'b1;
      grantIdx = '0;
    end
`endif
  end

  // Winner address mux and one-hot decodes of the winner and the FIFO head tag
  assign headIdx = tagMem[headPtr];

  always_comb begin
    grantAddr = '0;
    grantOh   = '0;
    headOh    = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grantIdx == IDX_W'(i)) begin
        grantAddr  = bus.req_addr[i*ADDR_W +: ADDR_W];
        grantOh[i] = 1'b1;
      end
      if (headIdx == IDX_W'(i)) headOh[i] = 1'b1;
    end
  end

  // A grant needs a free request slot: IDLE, or ISSUE whose request is acked now
  assign grantOk = grantAny && eligible && ((state == IDLE) || bus.mem_rd_ack);

`ifdef ANFFL_TEX_ARB_META_PRIO_EN
  assign rrAdv = grantOk && (grantIdx != '0);
`else
  assign rrAdv = grantOk;
`endif

  // Next-state logic: IDLE waits for a grant, ISSUE holds until acked
  always_comb begin
    stateNxt = state;
    case (state)
      IDLE:    if (grantOk) stateNxt = ISSUE;
      ISSUE:   if (bus.mem_rd_ack && !grantOk) stateNxt = IDLE;
      default: stateNxt = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= stateNxt;
  end

  // Registered request address/owner and round-robin pointer
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      memRdAddr <= '0;
      curIdx    <= '0;
      rrPtr     <= '0;
    end else begin
      if (grantOk) begin
        memRdAddr <= grantAddr;
        curIdx    <= grantIdx;
      end
      if (rrAdv) begin
        rrPtr <= (grantIdx == IDX_W'(NUM_REQ - 1)) ? '0 : grantIdx + IDX_W'(1);
      end
    end
  end

  // Tag FIFO pointers and occupancy
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count   <= '0;
      headPtr <= '0;
      tailPtr <= '0;
    end else begin
      count <= cntAfter;
      if (push) tailPtr <= tailPtr + PTR_W'(1);
      if (pop)  headPtr <= headPtr + PTR_W'(1);
    end
  end

  // Tag storage; contents are only meaningful between push and pop
  always_ff @(posedge clk) begin
    if (push) tagMem[tailPtr] <= curIdx;
  end

  // Response strobe/data one cycle after memory return; sticky orphan flag
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      respValid <= '0;
      respData  <= '0;
      errOrphan <= 1'b0;
    end else begin
      respValid <= pop ? headOh : '0;
      if (pop) respData <= bus.mem_rd_data;
      if (bus.mem_rd_valid && (count == '0)) errOrphan <= 1'b1;
    end
  end

  assign bus.req_ready   = (grantOk && reset) ? grantOh : '0;
  assign bus.mem_rd_req  = (state == ISSUE);
  assign bus.mem_rd_addr = memRdAddr;
  assign bus.resp_valid  = respValid;
  assign bus.resp_data   = respData;
  assign bus.err_orphan  = errOrphan;

endmodule

// File: tb/tb_anf_fl_tex_mem_arb.sv
// Bench for anf_fl_tex_mem_arb: directed scenarios plus randomized traffic, all
// checked every cycle against a transaction-level model (queue of outstanding
// owners, one pending request slot, round-robin pointer).
module tb_anf_fl_tex_mem_arb;

  localparam int unsigned NR = 3;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 64;
  localparam int unsigned MO = 4;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  anf_fl_tex_mem_arb_if #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW)) bus ();

  anf_fl_tex_mem_arb #(
    .NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .MAX_OUT(MO)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int nVec = 0;
  int nMis = 0;

  // reference model state
  int            outQ[$];
  bit            pendV;
  logic [AW-1:0] pendA;
  int            pendI;
  int            rr;
  logic [NR-1:0] mRespV;
  logic [DW-1:0] mRespD;
  bit            mOrph;

  // client and memory stimulus state
  bit            cliPend [NR];
  logic [AW-1:0] cliAddr [NR];
  bit            dAck;
  bit            dMv;
  logic [DW-1:0] dMd;
  int            strobeCnt;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nVec++;
    if (act !== exp) begin
      nMis++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int oh2i(input logic [NR-1:0] v);
    for (int i = 0; i < NR; i++) if (v[i]) return i;
    return -1;
  endfunction

  function automatic int pickWinner();
`ifdef ANFFL_TEX_ARB_META_PRIO_EN
    if (cliPend[0]) return 0;
    for (int k = 0; k < NR; k++) begin
      int c;
      c = (rr + k) % NR;
      if (c != 0 && cliPend[c]) return c;
    end
`else
    for (int k = 0; k < NR; k++) begin
      int c;
      c = (rr + k) % NR;
      if (cliPend[c]) return c;
    end
`endif
    return -1;
  endfunction

  task automatic modelReset();
    outQ.delete();
    pendV  = 1'b0;
    pendA  = '0;
    pendI  = 0;
    rr     = 0;
    mRespV = '0;
    mRespD = '0;
    mOrph  = 1'b0;
    for (int i = 0; i < NR; i++) cliPend[i] = 1'b0;
  endtask

  task automatic raise(input int i);
    if (!cliPend[i]) begin
      cliPend[i] = 1'b1;
      cliAddr[i] = $urandom;
    end
  endtask

  // compare DUT against the model for the current cycle, then advance the model
  task automatic step();
    logic [NR-1:0] expReady;
    int            w;
    int            id;
    bit            popping;
    bit            pushing;
    if (!reset) begin
      chk("rst_req_ready",   64'(bus.req_ready),   64'(0));
      chk("rst_mem_rd_req",  64'(bus.mem_rd_req),  64'(0));
      chk("rst_mem_rd_addr", 64'(bus.mem_rd_addr), 64'(0));
      chk("rst_resp_valid",  64'(bus.resp_valid),  64'(0));
      chk("rst_resp_data",   64'(bus.resp_data),   64'(0));
      chk("rst_err_orphan",  64'(bus.err_orphan),  64'(0));
      modelReset();
      return;
    end
    popping  = dMv && (outQ.size() > 0);
    pushing  = pendV && dAck;
    w        = pickWinner();
    expReady = '0;
    // reads granted but not yet returned may never exceed MO
    if (w >= 0 && (!pendV || dAck) &&
        (outQ.size() + int'(pendV) - int'(popping) + 1 <= int'(MO)))
      expReady[w] = 1'b1;

    chk("req_ready",  64'(bus.req_ready),  64'(expReady));
    chk("mem_rd_req", 64'(bus.mem_rd_req), 64'(pendV));
    if (pendV) chk("mem_rd_addr", 64'(bus.mem_rd_addr), 64'(pendA));
    chk("resp_valid", 64'(bus.resp_valid), 64'(mRespV));
    if (mRespV != '0) chk("resp_data", 64'(bus.resp_data), 64'(mRespD));
    chk("err_orphan", 64'(bus.err_orphan), 64'(mOrph));
    if (bus.resp_valid != '0) strobeCnt++;

    if (dMv && outQ.size() == 0) mOrph = 1'b1;
    mRespV = '0;
    if (popping) begin
      id         = outQ.pop_front();
      mRespV[id] = 1'b1;
      mRespD     = dMd;
    end
    if (pushing) begin
      outQ.push_back(pendI);
      pendV = 1'b0;
    end
    if (expReady != '0) begin
      pendV      = 1'b1;
      pendA      = cliAddr[w];
      pendI      = w;
      cliPend[w] = 1'b0;
`ifdef ANFFL_TEX_ARB_META_PRIO_EN
      if (w != 0) rr = (w + 1) % NR;
`else
      rr = (w + 1) % NR;
`endif
    end
  endtask

  task automatic tick();
    @(negedge clk);
    for (int i = 0; i < NR; i++) begin
      bus.req_valid[i]            = cliPend[i];
      bus.req_addr[i*AW +: AW]    = cliAddr[i];
    end
    bus.mem_rd_ack   = dAck;
    bus.mem_rd_valid = dMv;
    bus.mem_rd_data  = dMd;
    #1;
    step();
  endtask

  // asynchronous reset assertion away from the clock edge, checked immediately
  task automatic doReset();
    @(negedge clk);
    #2;
    reset = 1'b0;
    dAck  = 1'b0;
    dMv   = 1'b0;
    #1;
    step();
    repeat (2) tick();
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic drain();
    for (int i = 0; i < NR; i++) cliPend[i] = 1'b0;
    for (int n = 0; n < 60 && (pendV || outQ.size() > 0); n++) begin
      dAck = 1'b1;
      dMv  = (outQ.size() > 0);
      dMd  = {$urandom, $urandom};
      tick();
    end
    chk("drain_bound", 64'(pendV || outQ.size() > 0), 64'(0));
    dAck = 1'b0;
    dMv  = 1'b0;
    repeat (2) tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int gseq[$];
    int rseq[$];
    int accepts;
    int others;
    bit got0;

    bus.req_valid    = '0;
    bus.req_addr     = '0;
    bus.mem_rd_ack   = 1'b0;
    bus.mem_rd_valid = 1'b0;
    bus.mem_rd_data  = '0;
    dAck = 1'b0;
    dMv  = 1'b0;
    dMd  = '0;
    strobeCnt = 0;
    for (int i = 0; i < NR; i++) cliAddr[i] = '0;
    modelReset();

    // power-on reset
    repeat (2) tick();
    @(negedge clk);
    reset = 1'b1;

    // single read through the whole path
    cliPend[0] = 1'b1;
    cliAddr[0] = 32'h1000;
    tick();
    chk("t1_req_ready", 64'(bus.req_ready), 64'(3'b001));
    tick();
    chk("t1_mem_rd_req",  64'(bus.mem_rd_req),  64'(1));
    chk("t1_mem_rd_addr", 64'(bus.mem_rd_addr), 64'(32'h1000));
    dAck = 1'b1;
    tick();
    dAck = 1'b0;
    dMv  = 1'b1;
    dMd  = 64'hA5;
    tick();
    dMv  = 1'b0;
    tick();
    chk("t1_resp_valid", 64'(bus.resp_valid), 64'(3'b001));
    chk("t1_resp_data",  64'(bus.resp_data),  64'(64'hA5));
    tick();
    chk("t1_resp_pulse", 64'(bus.resp_valid), 64'(0));

    // two clients contending, one read per cycle
    doReset();
    for (int n = 0; n < 14; n++) begin
      raise(0);
      raise(1);
      dAck = 1'b1;
      dMv  = (outQ.size() > 0);
      dMd  = {$urandom, $urandom};
      tick();
      if (bus.req_ready  != '0) gseq.push_back(oh2i(bus.req_ready));
      if (bus.resp_valid != '0) rseq.push_back(oh2i(bus.resp_valid));
    end
    chk("t2_grant_count", 64'(gseq.size() >= 6), 64'(1));
    chk("t2_resp_count",  64'(rseq.size() >= 4), 64'(1));
    if (gseq.size() >= 6)
      for (int k = 0; k < 6; k++) chk("t2_grant_order", 64'(gseq[k]), 64'(k % 2));
    if (rseq.size() >= 4)
      for (int k = 0; k < 4; k++) chk("t2_resp_order", 64'(rseq[k]), 64'(k % 2));
    drain();

    // fill to MAX_OUT, then a return frees a slot in the same cycle
    doReset();
    strobeCnt = 0;
    accepts   = 0;
    for (int n = 0; n < 10; n++) begin
      raise(0);
      dAck = 1'b1;
      dMv  = 1'b0;
      tick();
      if (bus.req_ready != '0) accepts++;
    end
    chk("t3_accepts",    64'(accepts),       64'(4));
    chk("t3_full_ready", 64'(bus.req_ready), 64'(0));
    dMv = 1'b1;
    dMd = {$urandom, $urandom};
    tick();
    chk("t3_free_grant", 64'(bus.req_ready), 64'(3'b001));

    // push and pop in the same cycle with the pipe at its limit
    raise(0);
    dAck = 1'b1;
    dMv  = 1'b1;
    dMd  = {$urandom, $urandom};
    tick();
    chk("t4_pushpop_grant", 64'(bus.req_ready), 64'(3'b001));
    dMv = 1'b0;
    tick();
    drain();
    chk("t4_strobes", 64'(strobeCnt), 64'(6));

    // orphan return, then reset with reads in flight
    doReset();
    dMv = 1'b1;
    dMd = 64'h1234;
    tick();
    dMv = 1'b0;
    tick();
    chk("t5_no_strobe", 64'(bus.resp_valid), 64'(0));
    chk("t5_orphan",    64'(bus.err_orphan), 64'(1));
    repeat (3) tick();
    chk("t5_orphan_sticky", 64'(bus.err_orphan), 64'(1));
    raise(0);
    raise(1);
    dAck = 1'b1;
    for (int n = 0; n < 10 && outQ.size() < 2; n++) tick();
    chk("t5_inflight", 64'(outQ.size()), 64'(2));
    dAck = 1'b0;
    doReset();
    dMv = 1'b1;
    tick();
    dMv = 1'b0;
    tick();
    chk("t5_prereset_orphan", 64'(bus.err_orphan), 64'(1));
    chk("t5_prereset_nostrb", 64'(bus.resp_valid), 64'(0));

    // port 1 streaming, port 0 joins
    doReset();
    for (int n = 0; n < 4; n++) begin
      raise(1);
      dAck = 1'b1;
      dMv  = (outQ.size() > 0);
      tick();
    end
    others = 0;
    got0   = 1'b0;
    for (int n = 0; n < 10 && !got0; n++) begin
      raise(0);
      raise(1);
      dAck = 1'b1;
      dMv  = (outQ.size() > 0);
      tick();
      if (bus.req_ready[0])          got0 = 1'b1;
      else if (bus.req_ready != '0)  others++;
    end
    chk("t6_port0_granted", 64'(got0), 64'(1));
`ifdef ANFFL_TEX_ARB_META_PRIO_EN
    chk("t6_port0_wait", 64'(others), 64'(0));
`else
    chk("t6_port0_wait", 64'(others <= 1), 64'(1));
`endif
    drain();

    // randomized traffic
    doReset();
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < NR; i++)
        if (!cliPend[i] && $urandom_range(0, 99) < 40) raise(i);
      dAck = ($urandom_range(0, 99) < 70);
      if (outQ.size() > 0) dMv = ($urandom_range(0, 99) < 50);
      else                 dMv = ($urandom_range(0, 199) == 0);
      dMd = {$urandom, $urandom};
      tick();
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
    $finish;
  end

endmodule
